// File: rtl/crc3_pkg.sv
// -----------------------------------------------------------------------------
// crc3_pkg
// Shared definitions for the 3-bit CRC (x^3 + x + 1) frame logic, used by both
// the receive-side checker and the transmit-side generator.
//   state_t    : receiver FSM encoding (IDLE, DATA, CRC, DONE)
//   CRC_W      : CRC register width
//   POLY       : generator polynomial without the implicit x^3 term
//   CRC_INIT   : CRC register value at every frame start
//   crc3_step  : one serial CRC update step
// -----------------------------------------------------------------------------
package crc3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int             CRC_W    = 3;
   localparam logic [CRC_W-1:0] POLY     = 3'b011;
   localparam logic [CRC_W-1:0] CRC_INIT = 3'b000;

   // Galois-style step: fb = crc[msb] ^ din, shift left, xor POLY when fb=1.
   // With POLY=011 this is {crc[1], crc[0]^fb, fb}.
   function automatic logic [CRC_W-1:0] crc3_step(input logic [CRC_W-1:0] crc,
                                                  input logic             din);
      logic fb;
      fb = crc[CRC_W-1] ^ din;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
   endfunction

endpackage

// File: rtl/crc3_lfsr.sv
// -----------------------------------------------------------------------------
// crc3_lfsr
// Serial CRC register for polynomial x^3 + x + 1.
//   clk       : clock, rising edge
//   clr       : synchronous clear to CRC_INIT (has priority over shift_en)
//   shift_en  : apply one CRC step with bit_in
//   bit_in    : serial input bit
//   remainder : current CRC register contents
// -----------------------------------------------------------------------------
module crc3_lfsr
   import crc3_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] remainder
);

   always_ff @(posedge clk) begin
      if (clr) begin
         remainder <= CRC_INIT;
      end else if (shift_en) begin
         remainder <= crc3_step(remainder, bit_in);
      end
   end

endmodule

// File: rtl/crc3_frame_rx.sv
// -----------------------------------------------------------------------------
// crc3_frame_rx
// Serial frame receiver: DATA_W payload bits MSB-first followed by 3 CRC bits
// MSB-first; checks the codeword against x^3 + x + 1.
//   CLK        : clock, rising edge
//   CLR        : synchronous active-high reset
//   Start      : frame-start strobe, honoured only in IDLE (CLR wins)
//   Bit_en     : qualifies Serial_In; Bit_en=0 freezes DATA/CRC completely
//   Serial_In  : serial codeword input
//   Data_out   : last received payload, held until the next frame completes
//   Valid      : one-cycle pulse (the DONE cycle) on frame completion
//   ERROR      : 1 when the last frame's remainder was non-zero, held
//   Busy       : high whenever the FSM is not in IDLE
//   fsm_state  : current FSM state, for observation
// Handshake: no back-pressure. A sender raises Start only while Busy=0; the
// frame result is presented on the single cycle Valid=1 and stays on
// Data_out/ERROR afterwards.
// -----------------------------------------------------------------------------
module crc3_frame_rx
   import crc3_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              Start,
   input  logic              Bit_en,
   input  logic              Serial_In,
   output logic [DATA_W-1:0] Data_out,
   output logic              Valid,
   output logic              ERROR,
   output logic              Busy,
   output state_t            fsm_state
);

   localparam int              CNT_W     = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_W - 1);

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   shift_reg;
   logic [DATA_W-1:0]   data_reg;
   logic                err_reg;
   logic [CRC_W-1:0]    crc;
   logic                frame_start;
   logic                sample;

   assign frame_start = (state == IDLE) && Start;
   assign sample      = Bit_en && ((state == DATA) || (state == CRC));

   crc3_lfsr u_lfsr (
      .clk       (CLK),
      .clr       (CLR || frame_start),
      .shift_en  (sample),
      .bit_in    (Serial_In),
      .remainder (crc)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (Start) state_next = DATA;
         DATA: if (Bit_en && (bit_cnt == LAST_DATA)) state_next = CRC;
         CRC:  if (Bit_en && (bit_cnt == LAST_CRC))  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state <= state_next;
         if (frame_start) begin
            bit_cnt <= '0;
         end else if (sample) begin
            // Counter wraps to 0 at the end of each phase so the CRC phase
            // reuses it from zero.
            if ((state == DATA && bit_cnt == LAST_DATA) ||
                (state == CRC  && bit_cnt == LAST_CRC)) begin
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
         if (sample && (state == DATA)) begin
            shift_reg <= {shift_reg[DATA_W-2:0], Serial_In};
         end
         if (state == DONE) begin
            data_reg <= shift_reg;
            err_reg  <= (crc != CRC_INIT);
         end
      end
   end

   // During DONE the result is shown straight from the shift register and
   // remainder so it is already valid alongside the Valid pulse; afterwards
   // the registered copy holds it.
   always_comb begin
      Valid     = (state == DONE);
      Busy      = (state != IDLE);
      fsm_state = state;
      Data_out  = (state == DONE) ? shift_reg : data_reg;
      ERROR     = (state == DONE) ? (crc != CRC_INIT) : err_reg;
   end

endmodule

// File: tb/tb_crc3_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_crc3_frame_rx
// Directed frames with hand-computed CRCs. Drivers push {err, data, cycle}
// expectations; a negedge monitor pops them on Valid and also checks that
// Data_out/ERROR hold between frames and clear after reset.
// -----------------------------------------------------------------------------
module tb_crc3_frame_rx;
   import crc3_pkg::*;

   logic       CLK = 1'b0;
   logic       CLR = 1'b1;
   logic       Start = 1'b0;
   logic       Bit_en = 1'b0;
   logic       Serial_In = 1'b0;
   logic [7:0] Data_out;
   logic       Valid;
   logic       ERROR;
   logic       Busy;
   state_t     fsm_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [40:0] exp_q[$];   // {err, data[7:0], valid_cycle[31:0]}

   crc3_frame_rx #(.DATA_W(8)) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .Start     (Start),
      .Bit_en    (Bit_en),
      .Serial_In (Serial_In),
      .Data_out  (Data_out),
      .Valid     (Valid),
      .ERROR     (ERROR),
      .Busy      (Busy),
      .fsm_state (fsm_state)
   );

   // clock / cycle count
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor / scoreboard
   logic       clr_next = 1'b0;
   logic [7:0] hold_data = 8'h00;
   logic       hold_err = 1'b0;

   always @(negedge CLK) begin
      logic [40:0] e;
      if (clr_next) begin
         hold_data = 8'h00;
         hold_err  = 1'b0;
         check("reset_outputs", {22'd0, Valid, Busy, ERROR, Data_out}, 32'd0);
      end else if (Valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("frame_data", {24'd0, Data_out}, {24'd0, e[39:32]});
            check("frame_error", {31'd0, ERROR}, {31'd0, e[40]});
            check("valid_cycle", cyc, e[31:0]);
            hold_data = e[39:32];
            hold_err  = e[40];
         end
      end else begin
         check("held_result", {23'd0, ERROR, Data_out}, {23'd0, hold_err, hold_data});
      end
      clr_next = CLR;
   end

   // drivers
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         Start = 1'b0;
         Bit_en = 1'b0;
         Serial_In = 1'b0;
      end
   endtask

   // cw = payload[7:0] followed by crc[2:0]; bit i is sampled on the last
   // sub-step of each stride, and its inverse is driven on stalled cycles.
   task automatic send_frame(input logic [10:0] cw, input logic exp_err, input int stride,
                             input bit mid_start, input bit done_start);
      int t0;
      step();
      Start = 1'b1;
      Bit_en = 1'b0;
      t0 = cyc;
      exp_q.push_back({exp_err, cw[10:3], 32'(t0 + 11 * stride + 1)});
      for (int i = 0; i < 11; i++) begin
         for (int s = 0; s < stride; s++) begin
            step();
            check("busy_in_frame", {31'd0, Busy}, 32'd1);
            check("state_in_frame", 32'(fsm_state), (i < 8) ? 32'(DATA) : 32'(CRC));
            Start = mid_start && (i == 4) && (s == 0);
            Bit_en = (s == stride - 1);
            Serial_In = Bit_en ? cw[10 - i] : ~cw[10 - i];
         end
      end
      step();
      check("state_done", 32'(fsm_state), 32'(DONE));
      Bit_en = 1'b0;
      Start = done_start;
      Serial_In = 1'b0;
   endtask

   task automatic abort_frame(input logic [10:0] cw);
      step();
      Start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         Start = 1'b0;
         Bit_en = 1'b1;
         Serial_In = cw[10 - i];
      end
      step();
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      Bit_en = 1'b0;
      check("abort_busy", {31'd0, Busy}, 32'd0);
      check("abort_state", 32'(fsm_state), 32'(IDLE));
      check("abort_data", {24'd0, Data_out}, 32'd0);
      check("abort_error", {31'd0, ERROR}, 32'd0);
      check("abort_valid", {31'd0, Valid}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      idle(3);
      CLR = 1'b0;
      step();
      check("reset_state", 32'(fsm_state), 32'(IDLE));
      check("reset_busy", {31'd0, Busy}, 32'd0);
      check("reset_data", {24'd0, Data_out}, 32'd0);
      idle(2);

      send_frame(11'b10100101_101, 1'b0, 1, 1'b0, 1'b0);   // 0xA5 clean
      idle(2);
      send_frame(11'b10101101_101, 1'b1, 1, 1'b0, 1'b0);   // bit 3 flipped
      idle(2);
      abort_frame(11'b10100101_101);
      idle(2);

      // Start together with CLR must not start a frame
      step();
      CLR = 1'b1;
      Start = 1'b1;
      step();
      CLR = 1'b0;
      Start = 1'b0;
      check("clr_beats_start", 32'(fsm_state), 32'(IDLE));
      idle(2);

      send_frame(11'b10100101_101, 1'b0, 1, 1'b0, 1'b0);   // clean after abort
      idle(2);
      send_frame(11'b00000000_000, 1'b0, 4, 1'b0, 1'b0);   // slow bit rate
      idle(2);

      // back-to-back frames, with stray Starts mid-frame and in DONE
      send_frame(11'b10100101_101, 1'b0, 1, 1'b1, 1'b1);
      send_frame(11'b00111100_001, 1'b0, 1, 1'b0, 1'b0);   // 0x3C, crc 001
      send_frame(11'b11111111_011, 1'b0, 1, 1'b0, 1'b0);   // 0xFF, crc 011
      send_frame(11'b11111111_000, 1'b1, 1, 1'b0, 1'b0);   // 0xFF, wrong crc
      idle(5);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
